// File: rtl/tl_mem_responder.sv
// tl_mem_responder: TileLink-UL responder (Get/PutFullData/PutPartialData) over a word-addressed 64-bit memory
// Params: DEPTH words, BASE byte address of word 0, LATENCY accept-to-d_valid cycles (>=1), SOURCE_W source id width
// Ports: clk, rst (sync, active-high); A channel a_valid/a_ready/a_opcode/a_param/a_size/a_source/a_address/a_mask/a_data;
//        D channel d_valid/d_ready/d_opcode/d_param/d_size/d_source/d_denied/d_data
// Macro TL_MEM_RANGE_CHECK_EN: deny requests outside [BASE, BASE+DEPTH*8); otherwise the index wraps modulo DEPTH
module tl_mem_responder #(
   parameter int          DEPTH    = 1024,
   parameter logic [63:0] BASE     = 64'h8000_0000,
   parameter int          LATENCY  = 1,
   parameter int          SOURCE_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [2:0]          a_opcode,
   input  logic [2:0]          a_param,
   input  logic [2:0]          a_size,
   input  logic [SOURCE_W-1:0] a_source,
   input  logic [63:0]         a_address,
   input  logic [7:0]          a_mask,
   input  logic [63:0]         a_data,
   output logic                d_valid,
   input  logic                d_ready,
   output logic [2:0]          d_opcode,
   output logic [1:0]          d_param,
   output logic [2:0]          d_size,
   output logic [SOURCE_W-1:0] d_source,
   output logic                d_denied,
   output logic [63:0]         d_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [63:0] mem [DEPTH];
   logic [63:0] offset;
   logic [AW-1:0] idx;
   logic accept, is_get, is_put, in_range, denied;
   logic unused_ok;
   assign offset = a_address - BASE;
   assign idx = offset[3 +: AW];
   assign is_get = a_opcode == 3'd4;
   assign is_put = a_opcode == 3'd0 || a_opcode == 3'd1;
`ifdef TL_MEM_RANGE_CHECK_EN
   assign in_range = a_address >= BASE && offset < 64'(DEPTH) * 64'd8;
`else
   assign in_range = 1'b1;
`endif
   assign denied = !(is_get || is_put) || !in_range;
   assign accept = a_valid && a_ready;
   assign d_param = 2'b0;
   assign unused_ok = ^{a_param, offset[2:0], offset[63:3+AW]};
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nxt;
   // cnt holds the WAIT cycles still to go; leaving at 1 puts RESP exactly LATENCY cycles after accept
   always_comb begin
      state_nxt = (state == IDLE) ? (accept ? (LATENCY == 1 ? RESP : WAIT) : IDLE) :
                  (state == WAIT) ? (cnt == CW'(1) ? RESP : WAIT) :
                  (d_ready ? IDLE : RESP);
   end
   always_comb begin
      a_ready = state == IDLE && !rst;
      d_valid = state == RESP;
   end
   always_ff @(posedge clk)
      if (rst) begin
         cnt      <= '0;
         d_opcode <= '0;
         d_size   <= '0;
         d_source <= '0;
         d_denied <= '0;
         d_data   <= '0;
      end else if (accept) begin
         cnt      <= CW'(LATENCY - 1);
         d_opcode <= is_get ? 3'd1 : 3'd0;
         d_size   <= a_size;
         d_source <= a_source;
         d_denied <= denied;
         d_data   <= (is_get && !denied) ? mem[idx] : '0;
      end else if (state == WAIT)
         cnt <= cnt - CW'(1);
   // Writes commit in the accept cycle, so any later Get sees them and a reset cannot undo them
   always_ff @(posedge clk)
      if (accept && is_put && !denied)
         for (int i = 0; i < 8; i++)
            if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
endmodule

// File: tb/tb_tl_mem_responder.sv
// tb_tl_mem_responder: directed and randomized checks of tl_mem_responder against a timestamp/array model
module tb_tl_mem_responder;
   localparam int DEPTH = 16, LAT = 3, SW = 4;
   localparam logic [63:0] BASE = 64'h8000_0000;
   logic clk = 0, rst = 1;
   logic a_valid = 0, a_ready, d_valid, d_ready = 0, d_denied;
   logic [2:0] a_opcode = 0, a_param = 0, a_size = 0, d_opcode, d_size;
   logic [SW-1:0] a_source = 0, d_source;
   logic [63:0] a_address = 0, a_data = 0, d_data;
   logic [7:0] a_mask = 0;
   logic [1:0] d_param;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   tl_mem_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT), .SOURCE_W(SW)) dut (
      .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
      .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
      .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
      .d_source(d_source), .d_denied(d_denied), .d_data(d_data));
   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   // Model: byte-level memory array plus a timestamp of when the pending response becomes visible
   logic [63:0] mm [DEPTH];
   bit m_busy = 0, m_zero = 0, ev = 0, started = 0, m_den;
   longint cyc = 0, vfrom = 0;
   logic [63:0] m_off, e_data = 0;
   int m_idx;
   logic [2:0] e_op = 0, e_size = 0;
   logic [SW-1:0] e_src = 0;
   logic e_den = 0;
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_busy = 0; m_zero = 1; started = 1;
         e_op = 0; e_size = 0; e_src = 0; e_den = 0; e_data = 0;
      end else if (!m_busy) begin
         if (a_valid) begin
            m_off = a_address - BASE;
            m_idx = int'((m_off >> 3) % DEPTH);
            m_den = !(a_opcode inside {3'd0, 3'd1, 3'd4});
`ifdef TL_MEM_RANGE_CHECK_EN
            if (a_address < BASE || m_off >= 64'(DEPTH) * 8) m_den = 1;
`endif
            e_op = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
            e_size = a_size; e_src = a_source; e_den = m_den;
            e_data = (a_opcode == 3'd4 && !m_den) ? mm[m_idx] : 64'd0;
            if (a_opcode <= 3'd1 && !m_den)
               for (int i = 0; i < 8; i++) if (a_mask[i]) mm[m_idx][8*i +: 8] = a_data[8*i +: 8];
            m_busy = 1; m_zero = 0; vfrom = cyc + LAT - 1;
         end
      end else if (cyc - 1 >= vfrom && d_ready) m_busy = 0;
      ev = m_busy && cyc >= vfrom;
   end
   always @(negedge clk) if (started) begin
      check("a_ready", a_ready, !rst && !m_busy);
      check("d_valid", d_valid, ev);
      check("d_param", d_param, 0);
      if (ev || m_zero) begin
         check("d_opcode", d_opcode, e_op);
         check("d_size", d_size, e_size);
         check("d_source", d_source, e_src);
         check("d_denied", d_denied, e_den);
         check("d_data", d_data, e_data);
      end
   end
   logic [63:0] r_data;
   logic [2:0] r_op;
   logic [SW-1:0] r_src;
   logic r_den;
   int r_lat;
   task automatic req(input logic [2:0] op, input logic [63:0] addr, input logic [7:0] mask,
                      input logic [63:0] data, input logic [SW-1:0] src, input int hold);
      int k = 0;
      while (!(started && !rst && !m_busy) && k < 100) begin @(negedge clk); k++; end
      if (k >= 100) check("req_idle_timeout", 1, 0);
      a_valid = 1; a_opcode = op; a_address = addr; a_mask = mask; a_data = data; a_source = src; a_size = 3'd3;
      d_ready = 0;
      @(negedge clk);
      a_valid = 0;
      k = 1;
      while (d_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      if (k >= 50) check("resp_timeout", 1, 0);
      r_lat = k; r_data = d_data; r_op = d_opcode; r_src = d_source; r_den = d_denied;
      repeat (hold) begin
         check("hold_a_ready", a_ready, 0);
         check("hold_d_valid", d_valid, 1);
         @(negedge clk);
      end
      d_ready = 1;
      @(negedge clk);
      d_ready = 0;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int sel;
      repeat (3) @(negedge clk);
      check("rst_a_ready", a_ready, 0);
      check("rst_d_valid", d_valid, 0);
      check("rst_d_data", d_data, 0);
      check("rst_d_source", d_source, 0);
      check("rst_d_denied", d_denied, 0);
      rst = 0;
      @(negedge clk);
      check("ready_after_rst", a_ready, 1);
      for (int i = 0; i < DEPTH; i++) req(3'd0, BASE + 64'(i) * 8, 8'hFF, {$urandom, $urandom}, SW'(i), 0);
      req(3'd0, BASE, 8'hFF, 64'hCAFEF00DDEADBEEF, 1, 0);
      req(3'd0, BASE + 64'h10, 8'hFF, 64'h1122334455667788, 3, 0);
      check("put_op", r_op, 0);
      check("put_src", r_src, 3);
      check("put_den", r_den, 0);
      check("put_data", r_data, 0);
      req(3'd4, BASE + 64'h10, 8'h00, 0, 5, 5);
      check("get_latency", r_lat, LAT);
      check("get_op", r_op, 1);
      check("get_data", r_data, 64'h1122334455667788);
      check("model_get_data", e_data, 64'h1122334455667788);
      check("ready_after_fire", a_ready, 1);
      check("valid_after_fire", d_valid, 0);
      req(3'd1, BASE + 64'h10, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 2, 0);
      req(3'd4, BASE + 64'h10, 8'h00, 0, 4, 0);
      check("partial_data", r_data, 64'h11223344AAAAAAAA);
      check("model_partial", e_data, 64'h11223344AAAAAAAA);
      req(3'd4, BASE + 64'(DEPTH) * 8, 8'h00, 0, 7, 0);
`ifdef TL_MEM_RANGE_CHECK_EN
      check("oor_den", r_den, 1);
      check("oor_data", r_data, 0);
`else
      check("wrap_den", r_den, 0);
      check("wrap_data", r_data, 64'hCAFEF00DDEADBEEF);
`endif
      req(3'd2, BASE + 64'h10, 8'hFF, 64'h0, 6, 0);
      check("bad_op", r_op, 0);
      check("bad_den", r_den, 1);
      req(3'd4, BASE + 64'h10, 8'h00, 0, 6, 0);
      check("bad_op_nowrite", r_data, 64'h11223344AAAAAAAA);
      a_valid = 1; a_opcode = 3'd4; a_address = BASE + 64'h10; a_source = 9;
      @(negedge clk);
      a_valid = 0;
      repeat (LAT - 1) @(negedge clk);
      check("resp_before_rst", d_valid, 1);
      rst = 1;
      @(negedge clk);
      check("rst_in_resp_valid", d_valid, 0);
      check("rst_in_resp_ready", a_ready, 0);
      rst = 0;
      @(negedge clk);
      check("ready_after_mid_rst", a_ready, 1);
      req(3'd4, BASE + 64'h10, 8'h00, 0, 1, 0);
      check("write_survives_rst", r_data, 64'h11223344AAAAAAAA);
      for (int n = 0; n < 3000; n++) begin
         rst = $urandom_range(0, 299) == 0;
         a_valid = $urandom_range(0, 2) != 0;
         sel = $urandom_range(0, 9);
         a_opcode = sel < 3 ? 3'd0 : sel < 5 ? 3'd1 : sel < 9 ? 3'd4 : 3'($urandom_range(0, 7));
         a_address = BASE + 64'($urandom_range(0, DEPTH - 1)) * 8 + 64'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0)
            a_address = $urandom_range(0, 1) ? BASE + 64'(DEPTH) * 8 + 64'($urandom_range(0, 255)) * 8
                                             : BASE - 64'($urandom_range(1, 64)) * 8;
         a_mask = 8'($urandom);
         a_data = {$urandom, $urandom};
         a_source = SW'($urandom);
         a_size = 3'($urandom);
         a_param = 3'($urandom);
         d_ready = $urandom_range(0, 3) != 0;
         @(negedge clk);
      end
      rst = 0; a_valid = 0; d_ready = 1;
      repeat (LAT + 2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tl_mem_responder.md
# tl_mem_responder

TileLink-UL responder (slave side) backing a word-addressed on-chip memory. It accepts one A-channel request at a time (Get, PutFullData, PutPartialData), performs the access, and returns exactly one D-channel response after a configurable latency. It sits behind the access stage's TileLink master port and serves as the memory/MMIO endpoint.

## Interface
- `DEPTH`, 1024: number of 64-bit words; power of two.
- `BASE`, 64'h8000_0000: byte address of word 0.
- `LATENCY`, 1: cycles from A acceptance to `d_valid`; must be ≥1.
- `SOURCE_W`, 4: width of the source ID.
- `clk` in 1: sole clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_valid` in 1: A-channel request valid.
- `a_ready` out 1: responder can accept A.
- `a_opcode` in 3: 0 PutFullData, 1 PutPartialData, 4 Get.
- `a_param` in 3: ignored.
- `a_size` in 3: log2 bytes; echoed on `d_size`.
- `a_source` in SOURCE_W: echoed on `d_source`.
- `a_address` in 64: byte address.
- `a_mask` in 8: byte enables.
- `a_data` in 64: write data.
- `d_valid` out 1: response valid.
- `d_ready` in 1: master accepts response.
- `d_opcode` out 3: 0 AccessAck, 1 AccessAckData.
- `d_param` out 2: always 0.
- `d_size` out 3, `d_source` out SOURCE_W: captured request fields.
- `d_denied` out 1: request rejected.
- `d_data` out 64: read data (0 unless AccessAckData and not denied).

## Operation
- States: IDLE, WAIT, RESP. `a_ready` = (state==IDLE) && !rst.
- IDLE: on `a_valid && a_ready` (accept) capture size/source/opcode; compute index = (a_address − BASE) >> 3, low log2(DEPTH) bits. Go to WAIT with counter = LATENCY−1, or straight to RESP if LATENCY==1.
- Get: read word at index in accept cycle into response register; `d_opcode`=1.
- PutFullData/PutPartialData: write bytes where `a_mask[i]`=1 at end of accept cycle; `d_opcode`=0, `d_data`=0. Full vs partial handled identically (mask honoured).
- Unsupported opcode (2,3,5,6,7): no memory access; `d_opcode`=0, `d_denied`=1.
- WAIT: decrement counter; at 0 go to RESP.
- RESP: `d_valid`=1; all d_* fields stable until `d_valid && d_ready`; then IDLE next cycle.
- `a_address[2:0]` ignored for indexing; `a_size` not checked against mask.

## Timing
- Reset: state IDLE; `d_valid`, `d_opcode`, `d_param`, `d_size`, `d_source`, `d_denied`, `d_data` all 0; `a_ready` 0 while `rst` high, 1 the cycle after. Memory contents not reset.
- Accept at cycle t → `d_valid` rises at t+LATENCY.
- With `d_ready` held high, back-to-back throughput is one request per LATENCY+1 cycles.
- Write visible to a Get accepted at any later cycle (no hazard window).
- `d_ready` low in RESP: hold indefinitely; `a_ready` stays 0.
- `rst` mid-WAIT/RESP: pending response discarded, outputs to reset values next cycle; a write already committed at acceptance persists.
- `d_ready` high while not in RESP: no effect.

## Configuration
- `TL_MEM_RANGE_CHECK_EN` defined: request with (a_address − BASE) ≥ DEPTH·8 or a_address < BASE gets `d_denied`=1, no write, `d_data`=0, opcode per request type; latency unchanged.
- Undefined: no range check; index wraps modulo DEPTH; `d_denied` only for unsupported opcodes.

## Test plan
- PutFullData BASE+0x10, data 0x1122334455667788, mask 0xFF, source 3 → AccessAck, source 3, denied 0; then Get BASE+0x10 → AccessAckData data 0x1122334455667788.
- PutPartialData BASE+0x10, data 0xAAAAAAAAAAAAAAAA, mask 0x0F → Get returns 0x11223344AAAAAAAA.
- LATENCY=3, d_ready held low 5 cycles after d_valid → d_valid at t+3, fields stable, a_ready 0 throughout; fire on d_ready, a_ready 1 next cycle.
- Get to BASE+DEPTH·8 with macro → denied 1, data 0; without macro → data of word 0.
- Opcode 2 → AccessAck denied 1, memory unchanged.
- Assert rst while in RESP → d_valid 0 next cycle, a_ready 1 after rst drops, earlier write still readable.
